// File: rtl/operand_fetch.sv
// Register-read stage: pending-write scoreboard, RAW/WAW interlock, one-entry output register.
// Optional write-back bypass into the operands: OPERAND_FETCH_BYPASS_EN.
module operand_fetch #(
  parameter int SIZE   = 16,
  parameter int DEPTH  = 8,
  parameter int CTRL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(DEPTH)-1:0] in_ra,
  input  logic [$clog2(DEPTH)-1:0] in_rb,
  input  logic [$clog2(DEPTH)-1:0] in_rc,
  input  logic                     in_wr,
  input  logic [CTRL_W-1:0]        in_ctrl,
  output logic [$clog2(DEPTH)-1:0] raddr0,
  output logic [$clog2(DEPTH)-1:0] raddr1,
  input  logic [SIZE-1:0]          read_data0,
  input  logic [SIZE-1:0]          read_data1,
  input  logic                     wb_valid,
  input  logic [$clog2(DEPTH)-1:0] wb_addr,
  input  logic [SIZE-1:0]          wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE-1:0]          out_a,
  output logic [SIZE-1:0]          out_b,
  output logic [$clog2(DEPTH)-1:0] out_rc,
  output logic                     out_wr,
  output logic [CTRL_W-1:0]        out_ctrl
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ZREG = AW'(DEPTH - 1);

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nx;
  logic [SIZE-1:0]  op_a, op_b;
  logic             byp_a, byp_b;
  logic             haz_a, haz_b, haz_waw;
  logic             accept;

  assign raddr0 = in_ra;
  assign raddr1 = in_rb;

  always_comb begin
`ifdef OPERAND_FETCH_BYPASS_EN
    byp_a = wb_valid && (wb_addr == in_ra);
    byp_b = wb_valid && (wb_addr == in_rb);
`else
    byp_a = 1'b0;
    byp_b = 1'b0;
`endif
    op_a = (in_ra == ZREG) ? '0 : (byp_a ? wb_data : read_data0);
    op_b = (in_rb == ZREG) ? '0 : (byp_b ? wb_data : read_data1);

    haz_a   = pending[in_ra] && (in_ra != ZREG) && !byp_a;
    haz_b   = pending[in_rb] && (in_rb != ZREG) && !byp_b;
    // A writer retiring this cycle frees its destination for the next writer.
    haz_waw = in_wr && (in_rc != ZREG) && pending[in_rc] &&
              !(wb_valid && (wb_addr == in_rc));

    in_ready = (!out_valid || out_ready) && !(haz_a || haz_b || haz_waw);
    accept   = in_valid && in_ready;
  end

  // Clear from write-back first so a same-cycle set on the same bit wins.
  always_comb begin
    pending_nx = pending;
    if (wb_valid)
      pending_nx[wb_addr] = 1'b0;
    if (accept && in_wr && (in_rc != ZREG))
      pending_nx[in_rc] = 1'b1;
    pending_nx[ZREG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_rc    <= '0;
      out_wr    <= 1'b0;
      out_ctrl  <= '0;
      pending   <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_a     <= op_a;
        out_b     <= op_b;
        out_rc    <= in_rc;
        out_wr    <= in_wr;
        out_ctrl  <= in_ctrl;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      pending <= pending_nx;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios followed by random traffic
// against a queue-based model of in-flight writers and the output stage.
module tb_operand_fetch;
  localparam int SIZE = 16, DEPTH = 8, CTRL_W = 8;
  localparam logic [2:0] Z = 3'd7;
`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready, in_wr = 1'b0;
  logic [2:0] in_ra = '0, in_rb = '0, in_rc = '0, raddr0, raddr1, wb_addr = '0, out_rc;
  logic [7:0] in_ctrl = '0, out_ctrl;
  logic [15:0] read_data0, read_data1, wb_data = '0, out_a, out_b;
  logic wb_valid = 1'b0, out_valid, out_ready = 1'b0, out_wr;

  logic [15:0] regs [DEPTH];
  assign read_data0 = regs[raddr0];
  assign read_data1 = regs[raddr1];

  operand_fetch #(.SIZE(SIZE), .DEPTH(DEPTH), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_wr(in_wr), .in_ctrl(in_ctrl),
    .raddr0(raddr0), .raddr1(raddr1), .read_data0(read_data0), .read_data1(read_data1),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_rc(out_rc), .out_wr(out_wr), .out_ctrl(out_ctrl));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rc;
    logic        wr;
    logic [7:0]  ctrl;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] outstanding[$];   // destinations accepted but not yet written back
  logic [2:0] retired[$];       // writers that left the output stage, awaiting write-back
  bit         stage_full;
  int         n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit is_out(input logic [2:0] r);
    foreach (outstanding[i]) if (outstanding[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] pend_model();
    logic [7:0] v = '0;
    foreach (outstanding[i]) v[outstanding[i]] = 1'b1;
    return v;
  endfunction

  // One cycle: drive, check at negedge, advance the model after the edge.
  task automatic step(input bit v, input logic [2:0] ra, rb, rc, input bit wr,
                      input logic [7:0] ctrl, input bit ordy,
                      input bit wbv, input logic [2:0] wba, input logic [15:0] wbd);
    bit ba, bb, ha, hb, waw, rdy, acc;
    exp_t e;
    in_valid = v; in_ra = ra; in_rb = rb; in_rc = rc; in_wr = wr; in_ctrl = ctrl;
    out_ready = ordy; wb_valid = wbv; wb_addr = wba; wb_data = wbd;
    @(negedge clk);
    ba  = BYP && wbv && wba == ra && ra != Z;
    bb  = BYP && wbv && wba == rb && rb != Z;
    ha  = ra != Z && is_out(ra) && !ba;
    hb  = rb != Z && is_out(rb) && !bb;
    waw = wr && rc != Z && is_out(rc) && !(wbv && wba == rc);
    rdy = (!stage_full || ordy) && !(ha || hb || waw);
    acc = v && rdy;
    e.a = (ra == Z) ? 16'h0 : (ba ? wbd : regs[ra]);
    e.b = (rb == Z) ? 16'h0 : (bb ? wbd : regs[rb]);
    e.rc = rc; e.wr = wr; e.ctrl = ctrl;
    chk("in_ready", in_ready, rdy);
    chk("raddr", {raddr0, raddr1}, {ra, rb});
    chk("pending", dut.pending, pend_model());
    @(posedge clk); #1;
    if (wbv) begin
      regs[wba] = wbd;
      foreach (outstanding[i]) if (outstanding[i] == wba) begin outstanding.delete(i); break; end
      foreach (retired[i]) if (retired[i] == wba) begin retired.delete(i); break; end
    end
    if (acc) begin
      exp_q.push_back(e);
      if (wr && rc != Z) outstanding.push_back(rc);
      stage_full = 1'b1;
    end else if (ordy) begin
      stage_full = 1'b0;
    end
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 16'h0);
  endtask

  // Reset cycle with an accept and a write-back offered; both must be overridden.
  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b1; in_ra = 3'd1; in_rb = 3'd2; in_rc = 3'd5; in_wr = 1'b1;
    in_ctrl = 8'hA5; out_ready = 1'b1; wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h1234;
    @(posedge clk); #1;
    regs[2] = 16'h1234;
    rst = 1'b1; in_valid = 1'b0; wb_valid = 1'b0;
    exp_q.delete(); outstanding.delete(); retired.delete(); stage_full = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ab", {out_a, out_b}, 32'h0);
    chk("rst_out_rc_wr_ctrl", {out_rc, out_wr, out_ctrl}, 12'h0);
    chk("rst_pending", dut.pending, 8'h00);
  endtask

  // Monitor: pops one expectation per output transfer and checks hold stability.
  bit   hold = 1'b0;
  exp_t prev;
  always @(negedge clk) begin
    if (!rst) begin
      hold = 1'b0;
    end else begin
      if (hold)
        chk("hold_stable", {out_valid, out_a, out_b, out_rc, out_wr, out_ctrl},
            {1'b1, prev.a, prev.b, prev.rc, prev.wr, prev.ctrl});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_a", out_a, e.a);
          chk("out_b", out_b, e.b);
          chk("out_rc_wr_ctrl", {out_rc, out_wr, out_ctrl}, {e.rc, e.wr, e.ctrl});
          if (e.wr && e.rc != Z) retired.push_back(e.rc);
        end
      end
      hold = out_valid && !out_ready;
      prev.a = out_a; prev.b = out_b; prev.rc = out_rc; prev.wr = out_wr; prev.ctrl = out_ctrl;
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) regs[i] = 16'(16'h0100 * i + i);
    regs[1] = 16'h0011; regs[2] = 16'h0022; regs[7] = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Basic read of two sources.
    step(1'b1, 3'd1, 3'd2, 3'd0, 1'b0, 8'h11, 1'b1, 1'b0, 3'd0, 16'h0);
    idle();

    // RAW on r3, write-back two cycles after the writer issues.
    step(1'b1, 3'd0, 3'd1, 3'd3, 1'b1, 8'h21, 1'b1, 1'b0, 3'd0, 16'h0);
    step(1'b1, 3'd3, 3'd1, 3'd0, 1'b0, 8'h22, 1'b1, 1'b0, 3'd0, 16'h0);
    step(1'b1, 3'd3, 3'd1, 3'd0, 1'b0, 8'h22, 1'b1, 1'b1, 3'd3, 16'hBEEF);
    step(1'b1, 3'd3, 3'd1, 3'd0, 1'b0, 8'h22, 1'b1, 1'b0, 3'd0, 16'h0);
    idle();

    // Zero register as source and destination, then an immediate follower.
    step(1'b1, 3'd7, 3'd7, 3'd7, 1'b1, 8'h31, 1'b1, 1'b0, 3'd0, 16'h0);
    step(1'b1, 3'd7, 3'd2, 3'd7, 1'b1, 8'h32, 1'b1, 1'b0, 3'd0, 16'h0);
    idle();

    // Backpressure for three cycles with a waiting instruction.
    step(1'b1, 3'd1, 3'd2, 3'd5, 1'b0, 8'h41, 1'b0, 1'b0, 3'd0, 16'h0);
    repeat (3) step(1'b1, 3'd2, 3'd1, 3'd6, 1'b0, 8'h42, 1'b0, 1'b0, 3'd0, 16'h0);
    step(1'b1, 3'd2, 3'd1, 3'd6, 1'b0, 8'h42, 1'b1, 1'b0, 3'd0, 16'h0);
    idle();

    // WAW on r4, released by a same-cycle write-back.
    step(1'b1, 3'd0, 3'd1, 3'd4, 1'b1, 8'h51, 1'b1, 1'b0, 3'd0, 16'h0);
    repeat (2) step(1'b1, 3'd0, 3'd1, 3'd4, 1'b1, 8'h52, 1'b1, 1'b0, 3'd0, 16'h0);
    step(1'b1, 3'd0, 3'd1, 3'd4, 1'b1, 8'h52, 1'b1, 1'b1, 3'd4, 16'h4444);
    idle();

    // Reset with a full output stage and four pending writers.
    do_reset();
    for (int r = 0; r < 4; r++)
      step(1'b1, 3'd5, 3'd6, 3'(r), 1'b1, 8'(8'h60 + r), 1'b1, 1'b0, 3'd0, 16'h0);
    step(1'b0, 3'd5, 3'd6, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("pre_reset_state", {out_valid, dut.pending}, {1'b1, 8'h0F});
    do_reset();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bit wbv = 1'b0;
      logic [2:0] wba = '0, r;
      if (retired.size() != 0 && $urandom_range(2) == 0) begin
        wbv = 1'b1;
        wba = retired[$urandom_range(retired.size() - 1)];
      end else if ($urandom_range(9) == 0) begin
        r = 3'($urandom_range(7));
        if (!is_out(r)) begin wbv = 1'b1; wba = r; end
      end
      step($urandom_range(3) != 0, 3'($urandom_range(7)), 3'($urandom_range(7)),
           3'($urandom_range(7)), 1'($urandom_range(1)), 8'($urandom),
           $urandom_range(3) != 0, wbv, wba, 16'($urandom));
    end
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read pipeline stage between instruction decode and the ALU stage. It accepts decoded instructions over a valid/ready handshake and drives the two register-file read addresses. It returns operands from the register file's combinational read ports, with register DEPTH-1 hard-wired to zero. A per-register pending-write scoreboard interlocks RAW and WAW hazards against in-flight writers, and the result is registered into a one-entry output stage for the ALU.

## Interface
- SIZE, 16, data width of one register
- DEPTH, 8, number of registers; register DEPTH-1 is the zero register
- CTRL_W, 8, width of opaque control bits passed through to the ALU stage
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_ra, in_rb  in  $clog2(DEPTH)  source register addresses
- in_rc  in  $clog2(DEPTH)  destination register address
- in_wr  in  1  instruction writes in_rc
- in_ctrl  in  CTRL_W  pass-through control
- raddr0, raddr1  out  $clog2(DEPTH)  register-file read addresses; combinationally equal to in_ra, in_rb
- read_data0, read_data1  in  SIZE  register-file read data, same cycle
- wb_valid  in  1  write-back occurring this cycle; the same signal drives the register-file write enable
- wb_addr  in  $clog2(DEPTH)  write-back address
- wb_data  in  SIZE  write-back data
- out_valid  out  1  operands valid to ALU stage
- out_ready  in  1  ALU stage accepts
- out_a, out_b  out  SIZE  operand values
- out_rc  out  $clog2(DEPTH)  registered destination address
- out_wr  out  1  registered write flag
- out_ctrl  out  CTRL_W  registered control

## Operation
- Scoreboard `pending[DEPTH-1:0]`: bit r set means an accepted instruction will write r and has not yet written back.
- Zero register Z = DEPTH-1:
  - operand value is 0 regardless of read_data.
  - never pending.
  - in_wr with in_rc==Z sets no bit.
- Source hazard on in_ra (same for in_rb): `pending[in_ra]` && in_ra != Z && the source is not bypassed (see Configuration).
- WAW hazard: in_wr && in_rc != Z && `pending[in_rc]`, unless wb_valid && wb_addr==in_rc this cycle.
- Readiness: in_ready = (!out_valid || out_ready) && !hazard, where hazard is any source or WAW hazard.
- Accept = in_valid && in_ready. On accept, the output register loads:
  - out_a and out_b, with the selected operand values;
  - out_rc, out_wr and out_ctrl, from the inputs;
  - out_valid = 1.
- Drain: if out_valid && out_ready and no accept, out_valid goes to 0 and the data registers hold.
- Scoreboard update each cycle:
  - wb_valid clears `pending[wb_addr]`.
  - Accept with in_wr && in_rc != Z sets `pending[in_rc]`.
  - If both hit the same bit, set wins.
- wb_valid to a non-pending register is legal: the register file is updated and the scoreboard is unchanged.
- in_ready does not depend on in_valid. The hazard is computed from in_ra, in_rb and in_rc regardless of in_valid.

## Timing
- Reset (rst==0 at a clock edge):
  - out_valid=0, out_a=0, out_b=0, out_rc=0, out_wr=0, out_ctrl=0.
  - pending cleared to all zeros.
  - Reset overrides a simultaneous accept or write-back.
  - Instructions in flight are dropped; writers of in-flight write-backs must be reset too.
- Latency: accepted in cycle N gives out_valid=1 in cycle N+1.
- Throughput: one instruction per cycle when there are no hazards and out_ready=1.
- Backpressure: while out_valid && !out_ready, all out_* hold stable and in_ready=0.
- No skid buffer: in_ready has a combinational path from out_ready.
- The register file writes on the clock edge, so a value written back in cycle N is readable through read_data in cycle N+1.

## Configuration
- OPERAND_FETCH_BYPASS_EN defined:
  - If wb_valid && wb_addr==in_ra (in_ra != Z), operand A takes wb_data and the source is not hazardous that cycle; the same applies to in_rb.
  - RAW hazards resolve in the write-back cycle.
- Undefined:
  - Operands always come from read_data (or 0 for Z).
  - A pending source stalls through the write-back cycle and is accepted in the cycle after, since the pending bit is clear and the register file is updated.
  - The RAW penalty is one extra cycle versus bypass.

## Test plan
- Reset, then issue ra=1, rb=2 with read_data0=0x0011, read_data1=0x0022 and out_ready=1 -> next cycle out_valid=1, out_a=0x0011, out_b=0x0022; pending all zero.
- Issue rc=3, wr=1, then ra=3; pulse wb_valid, wb_addr=3, wb_data=0xBEEF two cycles later -> with bypass: accepted in the write-back cycle, out_a=0xBEEF. Without bypass: accepted the following cycle, out_a=read_data0.
- ra=7 (Z) with read_data0=0xFFFF, and wr=1, rc=7 -> out_a=0, `pending[7]` stays 0, no stall on the next instruction.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, all out_* stable; first cycle with out_ready=1 -> the new instruction is accepted.
- WAW: rc=4 pending, second instruction with wr=1, rc=4 -> stalls until wb_addr=4; same-cycle wb and accept leaves `pending[4]`=1.
- Assert rst=0 with out_valid=1 and `pending`=0x0F -> next cycle out_valid=0, pending=0, out_a=out_b=0.
